// File: rtl/svn_seg_pkg.sv
// Shared definitions for the 7-segment loopback monitor.
// This file holds the segment pattern table, the pattern decoder and the sequence-state type.
package svn_seg_pkg;

    // Normalised (active-high) {dp,g,f,e,d,c,b,a} patterns, indexed by nibble.
    // Digit 0 is only recognised with its decimal point lit.
    localparam logic [15:0][7:0] Seg7Disp = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'hBF
    };

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } seq_state_e;

    // Returns {hit, nibble}. The whole 8-bit pattern must match a table entry.
    function automatic logic [4:0] seg_decode(input logic [7:0] pattern);
        logic [4:0] result;
        result = 5'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == Seg7Disp[i]) begin
                result = {1'b1, 4'(i)};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Synchronises the display lines, normalises polarity and accepts a pattern once it is stable.
// It produces a one-cycle accept strobe together with the pattern that was held steady.
module seg_stable_filter #(
    parameter logic LED_POLARITY  = 1'b0,
    parameter int   STABLE_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] seg_display_i,
    input  logic [2:0] seg_sel_i,
    output logic       accept_o,
    output logic [7:0] pattern_o
);

    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    // Raw level that normalises to blank, so leaving reset never looks like a new pattern.
    localparam logic [7:0] SYNC_IDLE = LED_POLARITY ? 8'h00 : 8'hFF;

    logic [7:0]       r_seg_meta;
    logic [7:0]       r_seg_sync;
    logic [2:0]       r_sel_meta;
    logic [2:0]       r_sel_sync;
    logic [7:0]       r_prev_norm;
    logic [7:0]       r_last;
    logic [CNT_W-1:0] r_cnt;

    logic [7:0] w_norm;
    logic       w_hold;

    assign w_norm    = LED_POLARITY ? r_seg_sync : ~r_seg_sync;
    assign w_hold    = (w_norm == r_prev_norm) && (r_sel_sync == 3'b111);
    assign accept_o  = w_hold && (r_cnt == CNT_MAX) && (r_prev_norm != r_last);
    assign pattern_o = r_prev_norm;

    // NOTE: every register here, synchroniser flops included, gets an explicit
    // reset value; sequential state is always written with non-blocking <=.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_seg_meta  <= SYNC_IDLE;
            r_seg_sync  <= SYNC_IDLE;
            r_sel_meta  <= 3'b000;
            r_sel_sync  <= 3'b000;
            r_prev_norm <= 8'h00;
            r_last      <= 8'h00;
            r_cnt       <= '0;
        end else begin
            r_seg_meta  <= seg_display_i;
            r_seg_sync  <= r_seg_meta;
            r_sel_meta  <= seg_sel_i;
            r_sel_sync  <= r_sel_meta;
            r_prev_norm <= w_norm;
            if (!w_hold) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (accept_o) begin
                r_last <= r_prev_norm;
            end
        end
    end

endmodule

// File: rtl/svn_seg_monitor.sv
// Loopback checker for the 3-digit 7-segment display path.
// It decodes stable patterns, checks the +1 count sequence and counts errors.
module svn_seg_monitor
    import svn_seg_pkg::*;
#(
    parameter int   CLK_IN_MHZ    = 125,
    parameter logic LED_POLARITY  = 1'b0,
    parameter int   STABLE_CYCLES = CLK_IN_MHZ / 8 + 1,
    parameter int   ERR_CNT_W     = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [7:0]           seg_display_i,
    input  logic [2:0]           seg_sel_i,
    output logic [3:0]           digit_o,
    output logic                 dp_o,
    output logic                 digit_valid_o,
    output logic                 invalid_o,
    output logic                 seq_err_o,
    output logic                 locked_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    logic       w_accept;
    logic [7:0] w_pattern;
    logic [4:0] w_dec;

    seq_state_e r_state;
    seq_state_e w_state_nxt;
    logic [3:0] r_expected;
    logic [3:0] w_expected_nxt;
    logic [3:0] w_digit_nxt;
    logic       w_dp_nxt;
    logic       w_valid_nxt;
    logic       w_invalid_nxt;
    logic       w_seq_err_nxt;

    seg_stable_filter #(
        .LED_POLARITY  (LED_POLARITY),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .seg_display_i (seg_display_i),
        .seg_sel_i     (seg_sel_i),
        .accept_o      (w_accept),
        .pattern_o     (w_pattern)
    );

    assign w_dec    = seg_decode(w_pattern);
    assign locked_o = (r_state == LOCKED);

    // NOTE: all outputs of this block get a default first so no latch is inferred.
    // An accepted blank pattern falls through with the defaults and changes nothing.
    always_comb begin
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        w_digit_nxt    = digit_o;
        w_dp_nxt       = dp_o;
        w_valid_nxt    = 1'b0;
        w_invalid_nxt  = 1'b0;
        w_seq_err_nxt  = 1'b0;
        if (w_accept && (w_pattern != 8'h00)) begin
            if (w_dec[4]) begin
                w_valid_nxt    = 1'b1;
                w_digit_nxt    = w_dec[3:0];
                w_dp_nxt       = w_pattern[7];
                w_expected_nxt = w_dec[3:0] + 4'd1;
                w_state_nxt    = LOCKED;
                w_seq_err_nxt  = (r_state == LOCKED) && (w_dec[3:0] != r_expected);
            end else begin
                w_invalid_nxt = 1'b1;
                w_state_nxt   = UNLOCKED;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state       <= UNLOCKED;
            r_expected    <= 4'd0;
            digit_o       <= 4'd0;
            dp_o          <= 1'b0;
            digit_valid_o <= 1'b0;
            invalid_o     <= 1'b0;
            seq_err_o     <= 1'b0;
            err_count_o   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_expected    <= w_expected_nxt;
            digit_o       <= w_digit_nxt;
            dp_o          <= w_dp_nxt;
            digit_valid_o <= w_valid_nxt;
            invalid_o     <= w_invalid_nxt;
            seq_err_o     <= w_seq_err_nxt;
            if ((w_invalid_nxt || w_seq_err_nxt) && (err_count_o != '1)) begin
                err_count_o <= err_count_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_svn_seg_monitor.sv
// Self-checking bench for svn_seg_monitor: directed scenarios plus a random walk,
// compared against a pattern-level reference model.
module tb_svn_seg_monitor;

    localparam int S = 16;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic [7:0] seg_display_i;
    logic [2:0] seg_sel_i;
    logic [3:0] digit_o;
    logic       dp_o;
    logic       digit_valid_o;
    logic       invalid_o;
    logic       seq_err_o;
    logic       locked_o;
    logic [7:0] err_count_o;

    svn_seg_monitor dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .seg_display_i (seg_display_i),
        .seg_sel_i     (seg_sel_i),
        .digit_o       (digit_o),
        .dp_o          (dp_o),
        .digit_valid_o (digit_valid_o),
        .invalid_o     (invalid_o),
        .seq_err_o     (seq_err_o),
        .locked_o      (locked_o),
        .err_count_o   (err_count_o)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] tbl [16] = '{8'hBF, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, in terms of displayed patterns and digits.
    logic [7:0] m_last;
    bit         m_locked;
    int         m_expected;
    int         m_digit;
    bit         m_dp;
    int         m_err;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic int lut(input logic [7:0] p);
        for (int i = 0; i < 16; i++) begin
            if (tbl[i] == p) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last = 8'h00; m_locked = 0; m_expected = 0; m_digit = 0; m_dp = 0; m_err = 0;
    endtask

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    // Drive a normalised pattern for a number of cycles and check the resulting pulses
    // and final outputs. Call aligned 1 time unit after a rising edge.
    task automatic apply(input logic [7:0] norm, input logic [2:0] sel, input int cycles,
                         input bit chk_lat);
        bit exp_acc, exp_v, exp_i, exp_s;
        int idx, n_v, n_i, n_s, first;
        exp_v = 0; exp_i = 0; exp_s = 0;
        exp_acc = (sel == 3'b111) && (cycles >= S + 4) && (norm != m_last);
        if (exp_acc) begin
            m_last = norm;
            if (norm != 8'h00) begin
                idx = lut(norm);
                if (idx < 0) begin
                    exp_i = 1; m_locked = 0; bump_err();
                end else begin
                    exp_v = 1;
                    if (m_locked && idx != m_expected) begin
                        exp_s = 1; bump_err();
                    end
                    m_locked = 1; m_expected = (idx + 1) % 16;
                    m_digit = idx; m_dp = norm[7];
                end
            end
        end
        seg_display_i = ~norm;
        seg_sel_i     = sel;
        n_v = 0; n_i = 0; n_s = 0; first = -1;
        for (int c = 1; c <= cycles; c++) begin
            @(posedge clk_i); #1;
            if (digit_valid_o) n_v++;
            if (invalid_o) n_i++;
            if (seq_err_o) n_s++;
            if ((digit_valid_o || invalid_o) && first < 0) first = c;
        end
        check("valid_pulses", n_v, exp_v);
        check("invalid_pulses", n_i, exp_i);
        check("seq_err_pulses", n_s, exp_s);
        if (chk_lat && (exp_v || exp_i)) check("latency", first, S + 3);
        check("digit", digit_o, m_digit);
        check("dp", dp_o, m_dp);
        check("locked", locked_o, m_locked);
        check("err_count", err_count_o, m_err);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_digit"}, digit_o, 0);
        check({tag, "_dp"}, dp_o, 0);
        check({tag, "_valid"}, digit_valid_o, 0);
        check({tag, "_invalid"}, invalid_o, 0);
        check({tag, "_seq_err"}, seq_err_o, 0);
        check({tag, "_locked"}, locked_o, 0);
        check({tag, "_err"}, err_count_o, 0);
    endtask

    initial begin
        logic [7:0] held, p;
        int r;
        model_reset();
        rstn_i = 1'b0;
        seg_display_i = 8'hFF;
        seg_sel_i = 3'b111;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;

        // "0." then "1"
        apply(8'hBF, 3'b111, 40, 1);
        apply(8'h06, 3'b111, 40, 1);
        // Count through the F -> 0 wrap
        apply(8'h79, 3'b111, 40, 1);
        apply(8'h71, 3'b111, 40, 1);
        apply(8'hBF, 3'b111, 40, 1);
        apply(8'h06, 3'b111, 40, 1);
        // 3 then 5 (sequence error), then 6
        apply(8'h4F, 3'b111, 40, 1);
        apply(8'h6D, 3'b111, 40, 1);
        apply(8'h7D, 3'b111, 40, 1);
        // Pattern outside the table
        apply(8'hFF, 3'b111, 40, 1);
        // Glitch inside a held digit
        apply(8'h7D, 3'b111, 40, 1);
        apply(8'h07, 3'b111, 5, 0);
        apply(8'h7D, 3'b111, 40, 0);
        // Digit-select loss while a new pattern is shown
        apply(8'h07, 3'b011, 40, 0);
        apply(8'h07, 3'b111, 40, 0);
        held = 8'h07;

        // Random walk
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 6) begin
                if (r <= 5 && m_locked) p = tbl[m_expected];
                else p = tbl[$urandom_range(0, 15)];
                apply(p, 3'b111, 40, 1);
                held = p;
            end else if (r == 7) begin
                p = 8'(1 + $urandom_range(0, 254));
                for (int t = 0; t < 64 && lut(p) >= 0; t++) p = 8'(1 + $urandom_range(0, 254));
                apply(p, 3'b111, 40, 1);
                held = p;
            end else if (r == 8) begin
                apply(8'h00, 3'b111, 40, 1);
                held = 8'h00;
            end else begin
                apply(8'($urandom_range(0, 255)), 3'b111, 5, 0);
                apply(held, 3'b111, 40, 0);
            end
        end

        // Reset while locked
        apply(8'h5B, 3'b111, 40, 0);
        apply(8'h4F, 3'b111, 40, 0);
        check("locked_before_reset", locked_o, 1);
        @(posedge clk_i); #3;
        rstn_i = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        apply(8'h4F, 3'b111, 40, 1);

        // Saturate the error counter
        for (int k = 0; k < 300; k++) begin
            apply((k % 2 == 0) ? 8'hFF : 8'hFE, 3'b111, S + 4, 1);
        end
        check("err_saturated", err_count_o, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
